// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first master with a valid/ready byte interface.
// The master is full-duplex, and tx_last closes the chip-select frame.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input. When loopback
// is high, the receive shifter samples the internal mosi register instead of miso.
module spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       miso
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYC - 1);
  // NEXT spends two cycles before it can accept a byte (the rx_valid cycle, then the
  // ready cycle). Those cycles count toward the following low half-period, which keeps
  // rising-edge spacing uniform across a byte boundary.
  localparam logic [CntW-1:0] LowPreload = CntW'(2);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StNext,
    StHold,
    StGap
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_div_cnt;
  logic [3:0]      r_bit_cnt;
  logic [6:0]      r_tx_sr;
  logic [7:0]      r_rx_sr;
  logic            r_last;
  logic            r_sclk;
  logic            r_cs_n;
  logic            r_mosi;
  logic [7:0]      r_rx_byte;
  logic            r_rx_valid;
  logic            r_miso_meta;
  logic            r_miso_sync;

  logic            w_div_done;
  logic            w_gap_done;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;
  logic            w_cs_rise;
  logic            w_timed;
  logic            w_rx_bit;

  assign w_div_done = (r_div_cnt == DivLast);
  assign w_gap_done = (r_div_cnt == GapLast);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_rx_bit = loopback ? r_mosi : r_miso_sync;
`else
  assign w_rx_bit = r_miso_sync;
`endif

  assign sclk     = r_sclk;
  assign cs_n     = r_cs_n;
  assign mosi     = r_mosi;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StSetup;
      StSetup: if (w_div_done) w_state_next = StHigh;
      StHigh:  if (w_div_done) w_state_next = (r_bit_cnt == 4'd8) ? StNext : StLow;
      StLow:   if (w_div_done) w_state_next = StHigh;
      StNext: begin
        if (r_last) begin
          w_state_next = StHold;
        end else if (w_accept) begin
          w_state_next = StLow;
        end
      end
      StHold:  if (w_div_done) w_state_next = StGap;
      StGap:   if (w_gap_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs and event strobes decoded from the current state.
  always_comb begin
    tx_ready  = 1'b0;
    busy      = (r_state != StIdle);
    w_rise    = 1'b0;
    w_fall    = 1'b0;
    w_cs_rise = 1'b0;
    w_timed   = 1'b0;
    case (r_state)
      StIdle:  tx_ready = ~rst;
      StSetup: begin
        w_rise  = w_div_done;
        w_timed = 1'b1;
      end
      StLow: begin
        w_rise  = w_div_done;
        w_timed = 1'b1;
      end
      StHigh: begin
        w_fall  = w_div_done;
        w_timed = 1'b1;
      end
      // The rx_valid cycle blocks acceptance so the two strobes never coincide.
      StNext:  tx_ready = ~rst & ~r_last & ~r_rx_valid;
      StHold: begin
        w_cs_rise = w_div_done;
        w_timed   = 1'b1;
      end
      StGap:   w_timed = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = tx_ready & tx_valid;

  // Two-flop synchroniser for the asynchronous miso input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  // Half-period counter, which restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if ((r_state == StNext) && w_accept) begin
      r_div_cnt <= LowPreload;
    end else if (w_state_next != r_state) begin
      r_div_cnt <= '0;
    end else if (w_timed) begin
      r_div_cnt <= r_div_cnt + CntW'(1);
    end
  end

  // Shift registers, SPI pins and the receive strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_tx_sr   <= tx_byte[6:0];
        r_last    <= tx_last;
        r_mosi    <= tx_byte[7];
        r_bit_cnt <= '0;
        r_cs_n    <= 1'b0;
      end
      if (w_rise) begin
        r_sclk    <= 1'b1;
        r_rx_sr   <= {r_rx_sr[6:0], w_rx_bit};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (r_bit_cnt == 4'd8) begin
          r_rx_byte  <= r_rx_sr;
          r_rx_valid <= 1'b1;
        end else begin
          r_mosi  <= r_tx_sr[6];
          r_tx_sr <= {r_tx_sr[5:0], 1'b0};
        end
      end
      if (w_cs_rise) begin
        r_cs_n <= 1'b1;
      end
    end
  end

endmodule
